// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EXE-stage multiply/divide sequencer:
// FSM state codes, operation kinds and the divide-by-zero LO fill.
package muldiv_ctrl_pkg;

    // Default datapath geometry for the 32-bit MIPS core.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    // Sequencer states: wait for work, iterate, then sign-fix and write HI/LO.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Operation kind latched at acceptance.
    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    // Fill bit replicated across LO when the divisor is zero (LO = all ones).
    localparam logic DIV0_LO = 1'b1;

endpackage

// File: rtl/muldiv_iter.sv
// One-step unsigned datapath for the multiply/divide unit.
// Holds the 2*WIDTH+1-bit accumulator and the fixed operand
// (multiplicand for mult, divisor for div). Each enabled cycle performs
// one shift-add (mult) or one restoring shift-subtract (div) step.
//
// Accumulator layout: [2W] guard bit, [2W-1:W] upper half
// (partial product / partial remainder), [W-1:0] lower half
// (multiplier being consumed / dividend being consumed and quotient bits).
module muldiv_iter
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     load_lo,
    input  logic [WIDTH-1:0]     load_opnd,
    output logic [2*WIDTH-1:0]   result
);

    logic [2*WIDTH:0] acc_q;
    logic [2*WIDTH:0] step_nxt;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   upper_sum;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   trial;

    // Compute the accumulator value after one mult or div iteration.
    always_comb begin
        upper_sum = '0;
        shifted   = '0;
        trial     = '0;
        step_nxt  = acc_q;
        if (!div_mode) begin
            // Add the multiplicand when the current multiplier bit is set,
            // keeping the carry in the guard bit, then shift everything right.
            upper_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
            step_nxt  = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
        end else begin
            // Shift the next dividend bit into the partial remainder and try
            // subtracting the divisor; a clear borrow bit means it fitted.
            shifted = {acc_q[2*WIDTH-1:0], 1'b0};
            trial   = shifted[2*WIDTH:WIDTH] - {1'b0, opnd_q};
            if (!trial[WIDTH]) begin
                step_nxt = {trial, shifted[WIDTH-1:1], 1'b1};
            end else begin
                step_nxt = shifted;
            end
        end
    end

    // Accumulator and operand registers: load on acceptance, step when enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc_q  <= {{(WIDTH+1){1'b0}}, load_lo};
            opnd_q <= load_opnd;
        end else if (en) begin
            acc_q  <= step_nxt;
        end
    end

    // The guard bit is always zero once an iteration completes.
    assign result = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit in the EXE stage.
// Accepts signed mult/div, runs WIDTH datapath iterations in muldiv_iter
// on operand magnitudes, applies the sign fix-up, and owns HI/LO.
// Requests that cannot be served yet (new op, mfhi, mflo) stall the front
// of the pipeline until the unit is idle again.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_e               state;
    state_e               state_nxt;
    op_e                  op_q;
    op_e                  op_sel;
    logic                 a_neg_q;
    logic                 b_neg_q;
    logic                 b_zero_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_iter;
    logic                 accept;
    logic                 iter_en;
    logic                 write_en;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     load_lo;
    logic [WIDTH-1:0]     load_opnd;
    logic [2*WIDTH-1:0]   result;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    // Two's complement magnitude; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign mag_a  = magnitude(op_a);
    assign mag_b  = magnitude(op_b);

    // Simultaneous mult and div is an illegal encoding; mult takes priority.
    assign op_sel = start_mult ? OP_MULT : OP_DIV;

    // Mult consumes the multiplier from the low half and adds the multiplicand;
    // div consumes the dividend from the low half and subtracts the divisor.
    assign load_lo   = (op_sel == OP_MULT) ? mag_b : mag_a;
    assign load_opnd = (op_sel == OP_MULT) ? mag_a : mag_b;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and control strobes for the IDLE -> CALC -> FIX loop.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        iter_en   = 1'b0;
        write_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if ((start_mult || start_div) && !flush) begin
                    accept    = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    iter_en = 1'b1;
                    if (last_iter) begin
                        state_nxt = S_FIX;
                    end
                end
            end
            S_FIX: begin
                write_en  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch operand signs and op kind on acceptance and count iterations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            op_q     <= op_sel;
            a_neg_q  <= op_a[WIDTH-1];
            b_neg_q  <= op_b[WIDTH-1];
            b_zero_q <= (op_b == '0);
        end else if (iter_en) begin
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    muldiv_iter #(
        .WIDTH     (WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .en        (iter_en),
        .div_mode  (op_q == OP_DIV),
        .load_lo   (load_lo),
        .load_opnd (load_opnd),
        .result    (result)
    );

    assign quo      = result[WIDTH-1:0];
    assign rem      = result[2*WIDTH-1:WIDTH];
    assign prod_fix = (a_neg_q ^ b_neg_q) ? -result : result;

    // Sign fix-up of the unsigned result into the values written to HI/LO.
    // A zero divisor never fails the trial subtract, so the remainder field
    // ends up holding |op_a| and the dividend-sign fix reproduces op_a in HI.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (op_q == OP_MULT) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else begin
            hi_d = a_neg_q ? -rem : rem;
            if (b_zero_q) begin
                lo_d = {WIDTH{DIV0_LO}};
            end else begin
                lo_d = (a_neg_q ^ b_neg_q) ? -quo : quo;
            end
        end
    end

    // HI/LO are written only in the FIX cycle, so an aborted op leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (write_en) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FIX);
    assign stall  = busy & (start_mult | start_div | rd_hi | rd_lo) & ~flush;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a scoreboard of expected HI/LO pairs.
// Expected values come from a behavioural signed multiply/divide model.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_mult;
    logic         start_div;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         rd_hi;
    logic         rd_lo;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    int           compared   = 0;
    int           mismatched = 0;
    logic [W-1:0] cur_hi     = '0;
    logic [W-1:0] cur_lo     = '0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    muldiv_ctrl #(
        .WIDTH      (W),
        .CNT_W      (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    // Signed MIPS mult/div reference returning {HI, LO}.
    function automatic logic [63:0] model(input bit is_div, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb_v;
        logic signed [31:0] da;
        logic signed [31:0] db;
        if (!is_div) begin
            sa   = $signed(a);
            sb_v = $signed(b);
            return sa * sb_v;
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        da = a;
        db = b;
        return {32'(da % db), 32'(da / db)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // kind: 0 = mult, 1 = div, 2 = both starts (mult expected to win).
    // Holds the start until accepted and returns in the first busy cycle.
    task automatic applyStimulus(input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit track, input string tag);
        int          n;
        logic [63:0] e;
        @(negedge clk);
        op_a       = a;
        op_b       = b;
        start_mult = (kind != 1);
        start_div  = (kind != 0);
        if (track) begin
            e = model(kind == 1, a, b);
            sb.push_back('{e[63:32], e[31:0], tag});
        end
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        check({tag, " accepted"}, 64'(busy), 64'(1));
    endtask

    // Watches one op to completion, then compares latency and result.
    task automatic checkOutput();
        int   n;
        int   d;
        int   s;
        exp_t e;
        #1;
        n = 0;
        d = 0;
        s = 0;
        while (busy && n < 200) begin
            n++;
            if (done) d++;
            if (stall) s++;
            @(negedge clk);
            #1;
        end
        e = sb.pop_front();
        check({e.tag, " busy cycles"}, 64'(n), 64'(33));
        check({e.tag, " done pulses"}, 64'(d), 64'(1));
        check({e.tag, " idle stall"}, 64'(s), 64'(0));
        check({e.tag, " hi/lo"}, {hi_out, lo_out}, {e.hi, e.lo});
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    initial begin
        exp_t        e;
        int          n;
        int          d;
        logic [63:0] m;

        rst        = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        rd_hi      = 1'b0;
        rd_lo      = 1'b0;
        flush      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset flags", 64'({busy, done, stall}), 64'(0));
        check("reset hi/lo", {hi_out, lo_out}, 64'(0));
        rst = 1'b1;

        $display("[TB] directed mult/div results");
        applyStimulus(0, 32'd7, 32'd7, 1'b1, "mult 7*7");                     checkOutput();
        applyStimulus(0, 32'hFFFF_FFFD, 32'd5, 1'b1, "mult -3*5");            checkOutput();
        applyStimulus(1, 32'd1025, 32'd2, 1'b1, "div 1025/2");                checkOutput();
        applyStimulus(1, 32'hFFFF_FFF9, 32'd2, 1'b1, "div -7/2");             checkOutput();
        applyStimulus(1, 32'd9, 32'd0, 1'b1, "div 9/0");                      checkOutput();
        applyStimulus(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div min/-1");   checkOutput();
        applyStimulus(0, 32'h8000_0000, 32'h8000_0000, 1'b1, "mult min*min"); checkOutput();
        applyStimulus(2, 32'd6, 32'hFFFF_FFFC, 1'b1, "both starts 6,-4");     checkOutput();
        applyStimulus(0, $urandom, $urandom, 1'b1, "mult random");            checkOutput();
        applyStimulus(1, $urandom, $urandom_range(1, 1000), 1'b1, "div random"); checkOutput();

        // mfhi arrives in the second busy cycle of div 1024/3.
        $display("[TB] mfhi while busy");
        applyStimulus(1, 32'd1024, 32'd3, 1'b1, "div 1024/3");
        @(negedge clk);
        rd_hi = 1'b1;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mfhi stall cycles", 64'(n), 64'(32));
        e = sb.pop_front();
        check("mfhi hi/lo", {hi_out, lo_out}, {e.hi, e.lo});
        cur_hi = e.hi;
        cur_lo = e.lo;
        rd_hi  = 1'b0;

        // A second mult waits out the first one, then is accepted.
        $display("[TB] second mult during busy");
        applyStimulus(0, 32'd12345, 32'hFFFF_FD5A, 1'b1, "mult A");
        @(negedge clk);
        op_a       = 32'hFFFF_FF9D;
        op_b       = 32'd1001;
        start_mult = 1'b1;
        m          = model(1'b0, op_a, op_b);
        sb.push_back('{m[63:32], m[31:0], "mult B"});
        #1;
        n = 0;
        d = 0;
        while (stall && n < 200) begin
            n++;
            if (done) d++;
            @(negedge clk);
            #1;
        end
        check("b2b stall cycles", 64'(n), 64'(32));
        check("b2b first done", 64'(d), 64'(1));
        e = sb.pop_front();
        check("b2b first hi/lo", {hi_out, lo_out}, {e.hi, e.lo});
        @(negedge clk);
        start_mult = 1'b0;
        check("b2b second accepted", 64'(busy), 64'(1));
        checkOutput();

        // Flush in the tenth CALC cycle aborts without touching HI/LO.
        $display("[TB] flush during CALC");
        applyStimulus(0, 32'd1000, 32'd1000, 1'b0, "mult flushed");
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush busy", 64'(busy), 64'(0));
        d = 0;
        repeat (40) begin
            if (done) d++;
            @(negedge clk);
        end
        check("flush done pulses", 64'(d), 64'(0));
        check("flush hi/lo", {hi_out, lo_out}, {cur_hi, cur_lo});

        // Flush in IDLE suppresses acceptance.
        @(negedge clk);
        op_a      = 32'd50;
        op_b      = 32'd7;
        start_div = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        start_div = 1'b0;
        flush     = 1'b0;
        check("idle flush no accept", 64'(busy), 64'(0));

        // Synchronous reset mid-CALC.
        $display("[TB] reset during CALC");
        applyStimulus(1, 32'd5000, 32'd7, 1'b0, "div reset");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst before edge busy", 64'(busy), 64'(1));
        check("rst before edge hi/lo", {hi_out, lo_out}, {cur_hi, cur_lo});
        @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst hi/lo", {hi_out, lo_out}, 64'(0));
        rst    = 1'b1;
        cur_hi = '0;
        cur_lo = '0;

        applyStimulus(1, 32'hFFFF_FF9C, 32'd7, 1'b1, "div -100/7 after reset"); checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
